// File: rtl/perceptron_trainer.sv
// perceptron_trainer: sample handshake, threshold decision and perceptron-rule weight update around weighted_sum; PERCEPTRON_WEIGHT_SAT_EN makes weight updates saturate instead of wrap
module perceptron_trainer #(
  parameter int                 N      = 8,
  parameter logic signed [31:0] THRESH = 32'sd0,
  parameter logic [31:0]        RATE   = 32'd1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_valid,
  output logic            sample_ready,
  input  logic [N-1:0]    sample_x,
  input  logic            sample_label,
  input  logic            sample_train,
  output logic [N-1:0]    x,
  output logic [32*N-1:0] w,
  input  logic [31:0]     sum,
  output logic            y_valid,
  output logic            y,
  output logic            error,
  output logic [15:0]     err_count
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DECIDE, UPDATE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] x_q, x_d;
  logic label_q, label_d, train_q, train_d;
  logic y_q, y_d, error_q, error_d, y_valid_q, y_valid_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] w_q [N];
  logic [31:0] w_d [N];
  logic hs, upd, decide, y_cmp;
  function automatic logic [31:0] step(input logic [31:0] v, input logic up);
`ifdef PERCEPTRON_WEIGHT_SAT_EN
    logic [33:0] t;
    t = up ? {{2{v[31]}}, v} + {2'b00, RATE} : {{2{v[31]}}, v} - {2'b00, RATE};
    return $signed(t) > 34'sh07FFFFFFF ? 32'h7FFFFFFF :
           $signed(t) < -34'sh080000000 ? 32'h80000000 : t[31:0];
`else
    return up ? v + RATE : v - RATE;
`endif
  endfunction
  assign sample_ready = state_q == IDLE;
  assign hs = sample_valid & sample_ready & !rst;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: if (hs) begin
        state_d = WAIT;
        cnt_d = CW'(N);
      end
      WAIT: if (cnt_q == CW'(1)) state_d = DECIDE;
            else cnt_d = cnt_q - CW'(1);
      DECIDE: state_d = UPDATE;
      UPDATE: state_d = IDLE;
    endcase
  end
  always_comb begin
    decide = state_q == DECIDE;
    upd = state_q == UPDATE && train_q && error_q;
    y_cmp = $signed(sum) >= THRESH;
    x_d = hs ? sample_x : x_q;
    label_d = hs ? sample_label : label_q;
    train_d = hs ? sample_train : train_q;
    y_d = decide ? y_cmp : y_q;
    error_d = decide ? y_cmp ^ label_q : error_q;
    y_valid_d = decide;
    err_count_d = upd && err_count_q != 16'hFFFF ? err_count_q + 16'd1 : err_count_q;
    for (int i = 0; i < N; i++) w_d[i] = upd && x_q[i] ? step(w_q[i], label_q) : w_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      x_q <= '0;
      label_q <= 1'b0;
      train_q <= 1'b0;
      y_q <= 1'b0;
      error_q <= 1'b0;
      y_valid_q <= 1'b0;
      err_count_q <= '0;
      for (int i = 0; i < N; i++) w_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      x_q <= x_d;
      label_q <= label_d;
      train_q <= train_d;
      y_q <= y_d;
      error_q <= error_d;
      y_valid_q <= y_valid_d;
      err_count_q <= err_count_d;
      for (int i = 0; i < N; i++) w_q[i] <= w_d[i];
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_w
    assign w[32*i +: 32] = w_q[i];
  end
  assign x = x_q;
  assign y = y_q;
  assign error = error_q;
  assign y_valid = y_valid_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: two trainers (default and saturation-boundary parameters) fed the same samples, scored against an arithmetic perceptron model
module tb_perceptron_trainer;
  localparam int N = 8;
  localparam int LAT = N + 1;
  localparam int W = 32 * N;
  logic clk = 1'b0, rst = 1'b1, sample_valid = 1'b0, sample_label = 1'b0, sample_train = 1'b0;
  logic [N-1:0] sample_x = '0;
  logic ready [2];
  logic [N-1:0] x_o [2];
  logic [W-1:0] w_o [2];
  logic [31:0] sum_i [2];
  logic yv [2], y_o [2], err_o [2];
  logic [15:0] ec [2];
  int total = 0, bad = 0, cyc = 0, hs_cnt = 0, hs_cyc = 0;
  int mw [2][N];
  int mec [2];
  int thr [2] = '{0, 32'h7FFFFFFF};
  int rate [2] = '{1, 32'h40000000};
  typedef struct packed {
    int hs;
    logic [1:0] y, e;
    logic [1:0][W-1:0] w;
    logic [1:0][15:0] ec;
  } exp_t;
  exp_t sb [$];
  logic [31:0] pipe [2][N];

  perceptron_trainer #(.N(N), .THRESH(32'sd0), .RATE(32'd1)) dut0 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(ready[0]),
    .sample_x(sample_x), .sample_label(sample_label), .sample_train(sample_train),
    .x(x_o[0]), .w(w_o[0]), .sum(sum_i[0]), .y_valid(yv[0]), .y(y_o[0]),
    .error(err_o[0]), .err_count(ec[0]));
  perceptron_trainer #(.N(N), .THRESH(32'sh7FFFFFFF), .RATE(32'h40000000)) dut1 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(ready[1]),
    .sample_x(sample_x), .sample_label(sample_label), .sample_train(sample_train),
    .x(x_o[1]), .w(w_o[1]), .sum(sum_i[1]), .y_valid(yv[1]), .y(y_o[1]),
    .error(err_o[1]), .err_count(ec[1]));

  always #5 clk = ~clk;

  // weighted_sum stand-in: N-cycle pipelined dot product of x and w
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < N; i++) if (x_o[k][i]) s = s + w_o[k][32*i +: 32];
      pipe[k][0] <= s;
      for (int j = 1; j < N; j++) pipe[k][j] <= pipe[k][j-1];
    end
  end
  assign sum_i[0] = pipe[0][N-1];
  assign sum_i[1] = pipe[1][N-1];

  function automatic int wstep(input int v, input int r, input bit up);
`ifdef PERCEPTRON_WEIGHT_SAT_EN
    longint t;
    t = up ? longint'(v) + longint'(r) : longint'(v) - longint'(r);
    return t > 64'sh7FFFFFFF ? 32'h7FFFFFFF : t < -64'sh80000000 ? 32'h80000000 : int'(t);
`else
    return up ? v + r : v - r;
`endif
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: classify and learn at the moment a sample is accepted
  always @(posedge clk) begin
    exp_t it;
    cyc++;
    if (sample_valid && ready[0] && !rst) begin
      it = '0;
      it.hs = cyc;
      for (int k = 0; k < 2; k++) begin
        int s;
        bit yb, eb;
        s = 0;
        for (int i = 0; i < N; i++) if (sample_x[i]) s += mw[k][i];
        yb = s >= thr[k];
        eb = yb ^ sample_label;
        if (sample_train && eb) begin
          for (int i = 0; i < N; i++) if (sample_x[i]) mw[k][i] = wstep(mw[k][i], rate[k], sample_label);
          if (mec[k] != 32'hFFFF) mec[k]++;
        end
        it.y[k] = yb;
        it.e[k] = eb;
        for (int i = 0; i < N; i++) it.w[k][32*i +: 32] = mw[k][i];
        it.ec[k] = mec[k][15:0];
      end
      sb.push_back(it);
      hs_cnt++;
      hs_cyc = cyc;
    end
  end

  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (yv[0] || yv[1]) begin
        if (sb.size() == 0) chk("spurious_y_valid", W'(1), W'(0));
        else begin
          it = sb.pop_front();
          chk("y_valid_both", W'({yv[0], yv[1]}), W'(2'b11));
          chk("latency", W'(cyc - it.hs), W'(LAT));
          for (int k = 0; k < 2; k++) begin
            chk($sformatf("y%0d", k), W'(y_o[k]), W'(it.y[k]));
            chk($sformatf("error%0d", k), W'(err_o[k]), W'(it.e[k]));
          end
          @(negedge clk);
          chk("y_valid_one_cycle", W'(yv[0] | yv[1]), W'(0));
          chk("ready_after_update", W'(ready[0] & ready[1]), W'(1));
          for (int k = 0; k < 2; k++) begin
            chk($sformatf("weights%0d", k), w_o[k], it.w[k]);
            chk($sformatf("err_count%0d", k), W'(ec[k]), W'(it.ec[k]));
          end
        end
      end
    end
  end

  task automatic clear_model();
    sb.delete();
    for (int k = 0; k < 2; k++) begin
      mec[k] = 0;
      for (int i = 0; i < N; i++) mw[k][i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] xv, input logic lb, input logic tr, input bit keep);
    int n0;
    n0 = hs_cnt;
    sample_x = xv;
    sample_label = lb;
    sample_train = tr;
    sample_valid = 1'b1;
    for (int i = 0; i < 40 && hs_cnt == n0; i++) @(negedge clk);
    chk("handshake", W'(hs_cnt != n0), W'(1));
    sample_valid = keep;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain", W'(sb.size()), W'(0));
  endtask

  initial begin
    int h1, h2, h3;
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", W'(ready[k]), W'(1));
      chk("reset_x", W'(x_o[k]), W'(0));
      chk("reset_w", w_o[k], W'(0));
      chk("reset_out", W'({yv[k], y_o[k], err_o[k]}), W'(0));
      chk("reset_err_count", W'(ec[k]), W'(0));
    end
    send(8'h01, 1'b1, 1'b0, 1'b0);
    drain();
    chk("inference_keeps_w", w_o[0], W'(0));
    do_reset();
    send(8'h05, 1'b0, 1'b1, 1'b0);
    drain();
    chk("train_w0", W'(w_o[0][31:0]), W'(32'hFFFFFFFF));
    chk("train_w2", W'(w_o[0][95:64]), W'(32'hFFFFFFFF));
    chk("train_w1", W'(w_o[0][63:32]), W'(0));
    chk("train_err_count", W'(ec[0]), W'(1));
    send(8'h05, 1'b0, 1'b0, 1'b0);
    drain();
    do_reset();
    repeat (3) begin
      send(8'h01, 1'b1, 1'b1, 1'b0);
      drain();
    end
`ifdef PERCEPTRON_WEIGHT_SAT_EN
    chk("sat_w0", W'(w_o[1][31:0]), W'(32'h7FFFFFFF));
`else
    chk("wrap_w0", W'(w_o[1][31:0]), W'(32'hC0000000));
`endif
    do_reset();
    send(8'h0F, 1'b1, 1'b1, 1'b1);
    h1 = hs_cyc;
    send(8'hF0, 1'b0, 1'b1, 1'b1);
    h2 = hs_cyc;
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    h3 = hs_cyc;
    chk("b2b_gap1", W'(h2 - h1), W'(N + 3));
    chk("b2b_gap2", W'(h3 - h2), W'(N + 3));
    drain();
    do_reset();
    send(8'h01, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    do_reset();
    chk("abort_ready", W'(ready[0]), W'(1));
    chk("abort_w", w_o[0], W'(0));
    chk("abort_err_count", W'(ec[0]), W'(0));
    repeat (N + 6) @(negedge clk);
    chk("abort_w_later", w_o[0], W'(0));
    force dut0.err_count_q = 16'hFFFF;
    @(negedge clk);
    release dut0.err_count_q;
    mec[0] = 32'hFFFF;
    send(8'h03, 1'b0, 1'b1, 1'b0);
    drain();
    chk("sat_err_count", W'(ec[0]), W'(16'hFFFF));
    chk("sat_count_w1", W'(w_o[0][63:32]), W'(32'hFFFFFFFF));
    do_reset();
    for (int n = 0; n < 40; n++)
      send(N'($urandom), 1'($urandom), 1'($urandom), ($urandom % 3) == 0);
    sample_valid = 1'b0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
